packet_out_collector: RTL and testbench

PACKET_OUT_COLLECTOR -- requirements
Module: packet_out_collector

---
 rtl/pkt_collector_pkg.sv | 38 +++
 rtl/pkt_fifo_mem.sv | 58 +++++
 rtl/packet_out_collector.sv | 144 ++++++++++++++
 tb/tb_packet_out_collector.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_collector_pkg.sv
// Shared definitions for the packet output collector.
// Holds FSM states, header field layout and checksum helpers.
package pkt_collector_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CHK,
        DISCARD
    } state_t;

    // Header layout: [7:6] destination, [5:0] payload length
    localparam int HDR_DEST_MSB = 7;
    localparam int HDR_DEST_LSB = 6;
    localparam int HDR_W        = HDR_DEST_MSB + 1;
    localparam int HDR_LEN_MSB  = HDR_DEST_LSB - 1;
    localparam int HDR_LEN_LSB  = 0;
    localparam int HDR_LEN_W    = HDR_LEN_MSB - HDR_LEN_LSB + 1;

    // Running checksum: XOR of header and every payload byte
    function automatic logic [HDR_W-1:0] chk_update(
        input logic [HDR_W-1:0] acc,
        input logic [HDR_W-1:0] b
    );
        return acc ^ b;
    endfunction

    // Counter increment that sticks at all-ones
    function automatic logic [15:0] sat_add(
        input logic [15:0] c,
        input logic [1:0]  inc
    );
        logic [16:0] s;
        s = {1'b0, c} + {15'b0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/pkt_fifo_mem.sv
// Storage array with read, speculative write, commit and rewind pointers.
// Readers only see entries below the commit pointer.
module pkt_fifo_mem #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 64,
    localparam int AW     = $clog2(DEPTH),
    localparam int PW     = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [DATA_W:0] i_wr_data,
    input  logic          i_commit,
    input  logic          i_rewind,
    input  logic          i_rd_ready,
    output logic [DATA_W:0] o_rd_data,
    output logic          o_not_empty,
    output logic [PW-1:0] o_commit_ptr,
    output logic [PW-1:0] o_rd_ptr
);

    logic [DATA_W:0] r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_commit_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   w_wr_base;
    logic            w_rd_fire;

    // A rewind lets a new write land at the committed position same cycle
    assign w_wr_base    = i_rewind ? r_commit_ptr : r_wr_ptr;
    assign o_not_empty  = (r_rd_ptr != r_commit_ptr);
    assign w_rd_fire    = o_not_empty & i_rd_ready;
    assign o_rd_data    = r_mem[r_rd_ptr[AW-1:0]];
    assign o_commit_ptr = r_commit_ptr;
    assign o_rd_ptr     = r_rd_ptr;

    // Pointer update: write, commit/rewind and read can all happen together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
        end else begin
            r_wr_ptr <= w_wr_base + PW'(i_wr_en);
            if (i_commit)
                r_commit_ptr <= r_wr_ptr;
            if (w_rd_fire)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_mem[w_wr_base[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/packet_out_collector.sv
// Collects switch output bytes, validates framing and checksum,
// and releases only whole good packets to the downstream consumer.
module packet_out_collector
    import pkt_collector_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_LEN    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] packet_out,
    input  logic              read_data_valid,
    input  logic              packet_out_start,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic [15:0]       pkt_ok_cnt,
    output logic [15:0]       pkt_err_cnt,
    output logic [15:0]       pkt_drop_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH) + 1;

    state_t               r_state, w_state_n;
    logic [HDR_LEN_W-1:0] r_rem, w_rem_n, w_len;
    logic [HDR_W-1:0]     r_chk, w_chk_n, w_byte_val;
    logic [15:0]          r_ok, r_err, r_drop;
    logic                 w_hdr, w_byte;
    logic                 w_len_bad, w_space_ok;
    logic                 w_wr_en, w_wr_last, w_commit, w_rewind;
    logic                 w_ok_inc, w_drop_inc;
    logic [1:0]           w_err_inc;
    logic [DATA_W:0]      w_rd_data;
    logic [PW-1:0]        w_commit_ptr, w_rd_ptr, w_used, w_free;

    assign w_hdr      = read_data_valid & packet_out_start;
    assign w_byte     = read_data_valid & ~packet_out_start;
    assign w_byte_val = packet_out[HDR_W-1:0];
    assign w_len      = packet_out[HDR_LEN_MSB:HDR_LEN_LSB];
    // Outside a packet wr_ptr equals commit_ptr, and an abort rewinds to it
    assign w_used     = w_commit_ptr - w_rd_ptr;
    assign w_free     = PW'(FIFO_DEPTH) - w_used;
    assign w_space_ok = 32'(w_free) >= (32'(w_len) + 32'd1);
    assign w_len_bad  = (w_len == '0) || (32'(w_len) > MAX_LEN);

    // Next-state and datapath control for one sampled byte
    always_comb begin
        w_state_n  = r_state;
        w_rem_n    = r_rem;
        w_chk_n    = r_chk;
        w_wr_en    = 1'b0;
        w_wr_last  = 1'b0;
        w_commit   = 1'b0;
        w_rewind   = 1'b0;
        w_ok_inc   = 1'b0;
        w_err_inc  = 2'd0;
        w_drop_inc = 1'b0;
        if (w_hdr) begin
            if (r_state == PAYLOAD || r_state == CHK) begin
                w_rewind  = 1'b1;
                w_err_inc = 2'd1;
            end
            if (w_len_bad) begin
                w_err_inc = w_err_inc + 2'd1;
                w_state_n = DISCARD;
            end else if (!w_space_ok) begin
                w_drop_inc = 1'b1;
                w_state_n  = DISCARD;
            end else begin
                w_wr_en   = 1'b1;
                w_rem_n   = w_len;
                w_chk_n   = w_byte_val;
                w_state_n = PAYLOAD;
            end
        end else if (w_byte) begin
            unique case (r_state)
                PAYLOAD: begin
                    w_wr_en   = 1'b1;
                    w_wr_last = (r_rem == HDR_LEN_W'(1));
                    w_chk_n   = chk_update(r_chk, w_byte_val);
                    w_rem_n   = r_rem - 1'b1;
                    if (r_rem == HDR_LEN_W'(1))
                        w_state_n = CHK;
                end
                CHK: begin
                    if (w_byte_val == r_chk) begin
                        w_commit = 1'b1;
                        w_ok_inc = 1'b1;
                    end else begin
                        w_rewind  = 1'b1;
                        w_err_inc = 2'd1;
                    end
                    w_state_n = IDLE;
                end
                default: ;
            endcase
        end
    end

    // FSM, packet tracking and saturating statistics
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_chk   <= '0;
            r_ok    <= '0;
            r_err   <= '0;
            r_drop  <= '0;
        end else begin
            r_state <= w_state_n;
            r_rem   <= w_rem_n;
            r_chk   <= w_chk_n;
            r_ok    <= sat_add(r_ok, {1'b0, w_ok_inc});
            r_err   <= sat_add(r_err, w_err_inc);
            r_drop  <= sat_add(r_drop, {1'b0, w_drop_inc});
        end
    end

    pkt_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_mem (
        .clk          (clk),
        .rst          (rst),
        .i_wr_en      (w_wr_en),
        .i_wr_data    ({w_wr_last, packet_out}),
        .i_commit     (w_commit),
        .i_rewind     (w_rewind),
        .i_rd_ready   (out_ready),
        .o_rd_data    (w_rd_data),
        .o_not_empty  (out_valid),
        .o_commit_ptr (w_commit_ptr),
        .o_rd_ptr     (w_rd_ptr)
    );

    assign out_data     = w_rd_data[DATA_W-1:0];
    assign out_last     = out_valid & w_rd_data[DATA_W];
    assign pkt_ok_cnt   = r_ok;
    assign pkt_err_cnt  = r_err;
    assign pkt_drop_cnt = r_drop;

endmodule

// File: tb/tb_packet_out_collector.sv
// Randomized scoreboard bench for packet_out_collector.
// A packet-level model predicts committed bytes and counter values.
module tb_packet_out_collector;

    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam int MAXL  = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  packet_out = '0;
    logic        rdv = 1'b0;
    logic        pstart = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid, out_last;
    logic [15:0] ok_c, err_c, drop_c;

    always #5 clk = ~clk;

    packet_out_collector #(
        .DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_LEN(MAXL)
    ) dut (
        .clk(clk), .rst(rst),
        .packet_out(packet_out),
        .read_data_valid(rdv),
        .packet_out_start(pstart),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_last(out_last),
        .out_ready(out_ready),
        .pkt_ok_cnt(ok_c),
        .pkt_err_cnt(err_c),
        .pkt_drop_cnt(drop_c)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0] sb[$];
    logic [7:0] pk[$];

    int         m_ok, m_err, m_drop, m_len;
    bit         m_active;
    logic [7:0] m_buf[$];

    bit rand_rdy = 0;
    bit gaps = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packet-level reference: decides fate of each sampled byte
    task automatic model_byte(input logic [7:0] b, input bit st);
        int L;
        logic [7:0] x;
        logic lst;
        if (st) begin
            if (m_active) m_err++;
            m_active = 0;
            L = int'(b[5:0]);
            if (L == 0 || L > MAXL) m_err++;
            else if (DEPTH - sb.size() < L + 1) m_drop++;
            else begin
                m_active = 1;
                m_len = L;
                m_buf.delete();
                m_buf.push_back(b);
            end
        end else if (m_active) begin
            if (m_buf.size() < m_len + 1) m_buf.push_back(b);
            else begin
                x = 8'h00;
                for (int i = 0; i < m_buf.size(); i++) x ^= m_buf[i];
                if (x == b) begin
                    m_ok++;
                    for (int i = 0; i < m_buf.size(); i++) begin
                        lst = (i == m_len);
                        sb.push_back({lst, m_buf[i]});
                    end
                end else m_err++;
                m_active = 0;
            end
        end
    endtask

    task automatic rnd_ready();
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit st);
        int n;
        n = 0;
        if (gaps && $urandom_range(0, 3) == 0) n = $urandom_range(1, 2);
        repeat (n) begin
            @(posedge clk); #1;
            rdv = 0;
            pstart = 1'($urandom_range(0, 1));
            packet_out = 8'($urandom);
            rnd_ready();
        end
        @(posedge clk); #1;
        packet_out = b;
        pstart = st;
        rdv = 1;
        rnd_ready();
        model_byte(b, st);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rdv = 0;
            pstart = 0;
            rnd_ready();
        end
    endtask

    task automatic send_pk();
        for (int i = 0; i < pk.size(); i++) send_byte(pk[i], i == 0);
    endtask

    function automatic logic [7:0] xsum();
        logic [7:0] x;
        x = 8'h00;
        foreach (pk[i]) x ^= pk[i];
        return x;
    endfunction

    task automatic check_cnts(input string tag);
        check({tag, "_ok"}, 32'(ok_c), 32'(m_ok));
        check({tag, "_err"}, 32'(err_c), 32'(m_err));
        check({tag, "_drop"}, 32'(drop_c), 32'(m_drop));
    endtask

    task automatic wait_drain(input string tag);
        int t;
        out_ready = 1;
        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check({tag, "_drain_left"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rst = 0;
        rdv = 0;
        pstart = 0;
        #1;
        check({tag, "_rst_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_rst_last"}, 32'(out_last), 32'd0);
        sb.delete();
        m_ok = 0; m_err = 0; m_drop = 0; m_active = 0;
        check_cnts({tag, "_rst"});
        @(posedge clk); #1;
        rst = 1;
    endtask

    task automatic good_pkt(input logic [7:0] hdr);
        pk.delete();
        pk.push_back(hdr);
        for (int i = 0; i < int'(hdr[5:0]); i++) pk.push_back(8'($urandom));
        pk.push_back(xsum());
        send_pk();
    endtask

    // Scoreboard monitor: compares every presented entry against the model
    logic [8:0] m_exp;
    always @(negedge clk) begin
        if (rst && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_spurious: got %0h expected none",
                         {out_last, out_data});
            end else begin
                m_exp = sb[0];
                if ({out_last, out_data} !== m_exp) begin
                    errors++;
                    $display("FAIL out_entry: got %0h expected %0h",
                             {out_last, out_data}, m_exp);
                end
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        int kind, L, d, k;
        logic [7:0] hdr;
        logic [5:0] lf;

        out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        check("init_valid", 32'(out_valid), 32'd0);
        check("init_last", 32'(out_last), 32'd0);
        m_ok = 0; m_err = 0; m_drop = 0; m_active = 0;
        check_cnts("init");
        rst = 1;

        // Basic packet with latency check
        pk = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_pk();
        @(negedge clk);
        check("lat_before", 32'(out_valid), 32'd0);
        idle(1);
        @(negedge clk);
        check("lat_after", 32'(out_valid), 32'd1);
        check("lat_hdr", 32'(out_data), 32'h03);
        wait_drain("basic");
        check_cnts("basic");

        // Bad checksum
        pk = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
        send_pk();
        idle(6);
        check("badchk_valid", 32'(out_valid), 32'd0);
        check_cnts("badchk");

        // Illegal lengths then a good packet
        send_byte(8'h00, 1);
        send_byte(8'h21, 1);
        send_byte(8'h5A, 0);
        pk = '{8'h43, 8'hAA, 8'hBB, 8'hCC, 8'h00};
        pk[4] = xsum();
        send_pk();
        idle(2);
        wait_drain("badlen");
        check_cnts("badlen");

        // Abort after two payload bytes
        send_byte(8'h03, 1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        pk = '{8'h82, 8'h55, 8'h66, 8'h00};
        pk[3] = xsum();
        send_pk();
        idle(2);
        wait_drain("abort");
        check_cnts("abort");

        // Fill to full with consumer stalled, 17th packet dropped
        out_ready = 0;
        for (int p = 0; p < 17; p++) begin
            pk = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
            pk[1] = 8'(p * 3);
            pk[2] = 8'(p * 3 + 1);
            pk[3] = 8'(p * 3 + 2);
            pk[4] = xsum();
            send_pk();
        end
        idle(2);
        check_cnts("full");
        check("full_sb", 32'(sb.size()), 32'd64);
        wait_drain("full");

        // Reset mid-payload
        send_byte(8'h03, 1);
        send_byte(8'h11, 0);
        do_reset("midpay");
        good_pkt(8'h04);
        idle(2);
        wait_drain("midpay");
        check_cnts("midpay");

        // Reset mid-drain
        out_ready = 0;
        for (int p = 0; p < 3; p++) good_pkt(8'h05);
        idle(1);
        out_ready = 1;
        idle(3);
        do_reset("middrain");
        good_pkt(8'hC3);
        idle(2);
        wait_drain("middrain");
        check_cnts("middrain");

        // Randomized traffic with backpressure and input gaps
        gaps = 1;
        rand_rdy = 1;
        for (int p = 0; p < 250; p++) begin
            kind = $urandom_range(0, 9);
            L = $urandom_range(1, MAXL);
            d = $urandom_range(0, 3);
            lf = 6'(L);
            hdr = {2'(d), lf};
            if (kind == 7) begin
                lf = ($urandom_range(0, 1) == 0) ? 6'd0
                     : 6'($urandom_range(MAXL + 1, 63));
                hdr = {2'(d), lf};
                send_byte(hdr, 1);
                k = $urandom_range(0, 4);
                for (int i = 0; i < k; i++) send_byte(8'($urandom), 0);
            end else if (kind == 8) begin
                k = $urandom_range(0, L);
                send_byte(hdr, 1);
                for (int i = 0; i < k; i++) send_byte(8'($urandom), 0);
            end else begin
                if (kind == 9) begin
                    k = $urandom_range(1, 3);
                    for (int i = 0; i < k; i++) send_byte(8'($urandom), 0);
                end
                pk.delete();
                pk.push_back(hdr);
                for (int i = 0; i < L; i++) pk.push_back(8'($urandom));
                pk.push_back(xsum());
                if (kind == 6) pk[L + 1] = pk[L + 1] ^ 8'($urandom_range(1, 255));
                send_pk();
            end
        end
        idle(3);
        gaps = 0;
        rand_rdy = 0;
        wait_drain("rand");
        idle(2);
        check_cnts("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
